d_hazard_scoreboard: RTL and testbench

- Parametrised decode-stage hazard controller for the pipelined MIPS core.
- Tracks every in-flight register writer beyond D in a shifting scoreboard, each with a Tnew countdown, plus a HI/LO multiply/divide busy counter.
- Produces the D-stage stall, the per-operand forward-source selects and md_busy.
- Consumes the Tuse/Tnew/MD decode outputs of the D control unit.

---
 rtl/d_hazard_scoreboard.sv | 113 +++++++++++
 tb/tb_d_hazard_scoreboard.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/d_hazard_scoreboard.sv
// Decode-stage hazard controller: a shifting scoreboard of in-flight GPR
// writers (index 0 = E) with Tnew countdowns, plus a HI/LO busy counter.
// Produces the D stall, per-operand forward selects and md_busy.
module d_hazard_scoreboard #(
    parameter int STAGES  = 3,
    parameter int ADDR_W  = 5,
    parameter int TNEW_W  = 2,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int SEL_W   = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_rs,
    input  logic [ADDR_W-1:0] d_rt,
    input  logic [TNEW_W-1:0] d_rs_tuse,
    input  logic [TNEW_W-1:0] d_rt_tuse,
    input  logic              d_wr_en,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic              d_md,
    input  logic              d_md_start,
    input  logic              d_md_div,
    input  logic              flush,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_sel_rs,
    output logic [SEL_W-1:0]  fwd_sel_rt,
    output logic              md_busy
);

    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [TNEW_W-1:0] tnew;
    } entry_t;

    entry_t             sb [STAGES];
    logic [CNT_W-1:0]   md_cnt;

    logic               rs_used;
    logic               rt_used;
    logic               found_rs;
    logic               found_rt;
    logic               haz_rs;
    logic               haz_rt;
    logic               accept;

    // Youngest-first operand lookup: the first valid match wins, older ones are ignored.
    always_comb begin
        rs_used    = (d_rs_tuse != '1) && (d_rs != '0);
        rt_used    = (d_rt_tuse != '1) && (d_rt != '0);
        found_rs   = 1'b0;
        found_rt   = 1'b0;
        haz_rs     = 1'b0;
        haz_rt     = 1'b0;
        fwd_sel_rs = '0;
        fwd_sel_rt = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (!found_rs && rs_used && sb[i].valid && (sb[i].addr == d_rs)) begin
                found_rs = 1'b1;
                haz_rs   = sb[i].tnew > d_rs_tuse;
                if (sb[i].tnew == '0)
                    fwd_sel_rs = SEL_W'(i + 1);
            end
            if (!found_rt && rt_used && sb[i].valid && (sb[i].addr == d_rt)) begin
                found_rt = 1'b1;
                haz_rt   = sb[i].tnew > d_rt_tuse;
                if (sb[i].tnew == '0)
                    fwd_sel_rt = SEL_W'(i + 1);
            end
        end
    end

    // Stall and issue decision, purely combinational from state and D inputs.
    always_comb begin
        md_busy = (md_cnt != '0);
        stall   = d_valid && !flush && (haz_rs || haz_rt || (d_md && md_busy));
        accept  = d_valid && !stall && !flush;
    end

    // Scoreboard shift: new writer enters E, older entries age with saturating Tnew.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < STAGES; i++)
                sb[i] <= '0;
        end else begin
            if (!flush && accept && d_wr_en && (d_wr_addr != '0))
                sb[0] <= '{valid: 1'b1, addr: d_wr_addr, tnew: d_tnew};
            else
                sb[0] <= '0;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sb[i].valid <= sb[i-1].valid && !flush;
                sb[i].addr  <= sb[i-1].addr;
                sb[i].tnew  <= (sb[i-1].tnew == '0) ? '0 : sb[i-1].tnew - TNEW_W'(1);
            end
        end
    end

    // HI/LO busy counter: loaded by an issued mult/div, ignores flush, counts down to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            md_cnt <= '0;
        else if (accept && d_md_start)
            md_cnt <= d_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        else if (md_cnt != '0)
            md_cnt <= md_cnt - CNT_W'(1);
    end

endmodule

// File: tb/tb_d_hazard_scoreboard.sv
// Directed bench for d_hazard_scoreboard: a per-cycle vector table checked
// before each edge, then hand sequences for MD latency and async reset.
module tb_d_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_rs, d_rt, d_wr_addr;
    logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
    logic       d_wr_en, d_md, d_md_start, d_md_div, flush;
    logic       stall, md_busy;
    logic [1:0] fwd_sel_rs, fwd_sel_rt;

    int total = 0;
    int bad   = 0;

    d_hazard_scoreboard #(
        .STAGES (3),
        .ADDR_W (5),
        .TNEW_W (2),
        .MUL_LAT(5),
        .DIV_LAT(10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .d_valid   (d_valid),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_rs_tuse (d_rs_tuse),
        .d_rt_tuse (d_rt_tuse),
        .d_wr_en   (d_wr_en),
        .d_wr_addr (d_wr_addr),
        .d_tnew    (d_tnew),
        .d_md      (d_md),
        .d_md_start(d_md_start),
        .d_md_div  (d_md_div),
        .flush     (flush),
        .stall     (stall),
        .fwd_sel_rs(fwd_sel_rs),
        .fwd_sel_rt(fwd_sel_rt),
        .md_busy   (md_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs, rt;
        logic [1:0] rs_tuse, rt_tuse;
        logic       we;
        logic [4:0] wa;
        logic [1:0] tn;
        logic       md, ms, mdiv, fl;
        logic       e_stall;
        logic [1:0] e_sel_rs, e_sel_rt;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input int rs, input int rt, input int rst, input int rtt,
                                input logic we, input int wa, input int tn,
                                input logic md, input logic ms, input logic mdiv, input logic fl,
                                input logic es, input int esr, input int est, input logic eb);
        vec_t r;
        r.v = v; r.rs = 5'(rs); r.rt = 5'(rt); r.rs_tuse = 2'(rst); r.rt_tuse = 2'(rtt);
        r.we = we; r.wa = 5'(wa); r.tn = 2'(tn);
        r.md = md; r.ms = ms; r.mdiv = mdiv; r.fl = fl;
        r.e_stall = es; r.e_sel_rs = 2'(esr); r.e_sel_rt = 2'(est); r.e_busy = eb;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        d_valid = r.v; d_rs = r.rs; d_rt = r.rt; d_rs_tuse = r.rs_tuse; d_rt_tuse = r.rt_tuse;
        d_wr_en = r.we; d_wr_addr = r.wa; d_tnew = r.tn;
        d_md = r.md; d_md_start = r.ms; d_md_div = r.mdiv; flush = r.fl;
    endtask

    // Count stalled cycles of the D instruction currently applied; busy must track stall.
    task automatic md_wait(input string name, input int exp_cycles);
        int n = 0;
        while (stall === 1'b1 && n < 40) begin
            chk({name, " busy during stall"}, 32'(md_busy), 32'd1);
            n++;
            @(negedge clk);
            #1;
        end
        chk({name, " stall cycles"}, n, exp_cycles);
        chk({name, " busy after"}, 32'(md_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Row: v rs rt rs_tuse rt_tuse we wa tn md ms mdiv fl | stall sel_rs sel_rt busy
        vecs.push_back(mk(0, 0, 0, 3, 3, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // reset state
        vecs.push_back(mk(1, 0, 0, 3, 3, 1,  8, 2, 0, 0, 0, 0, 0, 0, 0, 0)); // lw $8
        vecs.push_back(mk(1, 8, 8, 1, 1, 1,  9, 1, 0, 0, 0, 0, 1, 0, 0, 0)); // addu $9,$8,$8 stalls
        vecs.push_back(mk(1, 8, 8, 1, 1, 1,  9, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // lw in M tnew 1, issues
        vecs.push_back(mk(1, 8, 9, 1, 1, 1, 10, 1, 0, 0, 0, 0, 0, 3, 0, 0)); // $8 from W, $9 in E tnew1
        vecs.push_back(mk(1, 0, 0, 3, 3, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // nop
        vecs.push_back(mk(1, 0, 0, 3, 3, 1,  5, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // ori $5
        vecs.push_back(mk(1, 5, 5, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); // beq $5,$5 stalls
        vecs.push_back(mk(1, 5, 5, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 2, 2, 0)); // forward from M
        vecs.push_back(mk(1, 0, 0, 3, 3, 1,  3, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // addu $3
        vecs.push_back(mk(1, 0, 0, 3, 3, 1,  3, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // addu $3
        vecs.push_back(mk(1, 3, 3, 1, 1, 1,  4, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // youngest E wins over M
        vecs.push_back(mk(1, 4, 0, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // unused rs, rt=$0
        vecs.push_back(mk(1, 0, 0, 3, 3, 1,  0, 2, 0, 0, 0, 0, 0, 0, 0, 0)); // write to $0
        vecs.push_back(mk(1, 0, 4, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 3, 0)); // rs=$0 tuse0; $4 from W
        vecs.push_back(mk(1, 0, 0, 3, 3, 1,  8, 2, 0, 0, 0, 0, 0, 0, 0, 0)); // lw $8
        vecs.push_back(mk(1, 8, 8, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0)); // flush masks stall
        vecs.push_back(mk(1, 8, 8, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // entries gone after flush
        vecs.push_back(mk(1, 0, 0, 3, 3, 1,  7, 2, 0, 0, 0, 0, 0, 0, 0, 0)); // lw $7
        vecs.push_back(mk(0, 7, 0, 0, 3, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // invalid D never stalls
        vecs.push_back(mk(1, 7, 0, 0, 3, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); // M tnew1 > tuse0
        vecs.push_back(mk(1, 7, 0, 0, 3, 0,  0, 0, 0, 0, 0, 0, 0, 3, 0, 0)); // W forward
        vecs.push_back(mk(1, 0, 0, 3, 3, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0)); // mflo, md idle
        vecs.push_back(mk(1, 0, 0, 3, 3, 1,  6, 2, 0, 0, 0, 0, 0, 0, 0, 0)); // lw $6
        vecs.push_back(mk(1, 0, 6, 3, 1, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); // rt-only hazard
        vecs.push_back(mk(1, 0, 6, 3, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // M tnew1, no stall
        vecs.push_back(mk(1, 0, 0, 3, 3, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // nop

        reset = 1'b1;
        drive(vecs[0]);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d stall", i),  32'(stall),      32'(vecs[i].e_stall));
            chk($sformatf("v%0d sel_rs", i), 32'(fwd_sel_rs), 32'(vecs[i].e_sel_rs));
            chk($sformatf("v%0d sel_rt", i), 32'(fwd_sel_rt), 32'(vecs[i].e_sel_rt));
            chk($sformatf("v%0d busy", i),   32'(md_busy),    32'(vecs[i].e_busy));
        end

        // div then mflo: 10 stalled cycles
        @(negedge clk);
        drive(mk(1, 0, 0, 3, 3, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
        #1;
        chk("div issue stall", 32'(stall), 32'd0);
        @(negedge clk);
        drive(mk(1, 0, 0, 3, 3, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        #1;
        md_wait("div->mflo", 10);

        // mult, then a div held in D by the busy counter, then mflo
        @(negedge clk);
        drive(mk(1, 0, 0, 3, 3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        #1;
        chk("mult issue stall", 32'(stall), 32'd0);
        @(negedge clk);
        drive(mk(1, 0, 0, 3, 3, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
        #1;
        md_wait("mult->div", 5);
        @(negedge clk);
        drive(mk(1, 0, 0, 3, 3, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        #1;
        md_wait("stalled div->mflo", 10);

        // asynchronous reset in the middle of a div and a pending load-use
        @(negedge clk);
        drive(mk(1, 0, 0, 3, 3, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(mk(1, 0, 0, 3, 3, 1, 8, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(mk(1, 8, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("pre-reset stall", 32'(stall),   32'd1);
        chk("pre-reset busy",  32'(md_busy), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("async reset stall",  32'(stall),      32'd0);
        chk("async reset busy",   32'(md_busy),    32'd0);
        chk("async reset sel_rs", 32'(fwd_sel_rs), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(vecs[0]);
        #1;
        chk("post-reset busy", 32'(md_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
